// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multicycle control FSM for the MIPS-subset core. It sequences fetch, decode,
// execute, memory and writeback, and drives ALU op, datapath selects and the
// memory request handshake.
// Ports:
//   clk, rst_n          core clock (rising edge), async active-low reset
//   i_instr             IR contents, valid from DECODE until next fetch completes
//   i_alu_zero          ALU zero flag (same cycle as o_alu_ctrl)
//   i_mem_ready         memory completes the current request this cycle
//   o_mem_req/we/size   memory request, store qualifier, access size
//   o_ir_we, o_pc_we    IR load and PC update strobes
//   o_pc_src            0 = PC+4, 1 = branch target
//   o_alu_ctrl          4-bit ALU operation (0000 when idle)
//   o_alu_src_b         0 = rt, 1 = sign-ext imm16, 2 = zero-ext imm16
//   o_reg_we/dst        regfile write strobe and destination select
//   o_wb_sel            0 = ALU result, 1 = memory read data
//   o_illegal           sticky unsupported-instruction flag
module mips_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_instr,
    input  logic        i_alu_zero,
    input  logic        i_mem_ready,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [1:0]  o_mem_size,
    output logic        o_ir_we,
    output logic        o_pc_we,
    output logic        o_pc_src,
    output logic [3:0]  o_alu_ctrl,
    output logic [1:0]  o_alu_src_b,
    output logic        o_reg_we,
    output logic        o_reg_dst,
    output logic        o_wb_sel,
    output logic        o_illegal
);

    localparam logic [3:0] AluIdle = 4'b0000;
    localparam logic [3:0] AluAdd  = 4'b0101;
    localparam logic [3:0] AluSub  = 4'b0110;
    localparam logic [3:0] AluAnd  = 4'b0001;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0010;
    localparam logic [3:0] AluSltu = 4'b1000;
    localparam logic [3:0] AluSlt  = 4'b1001;
    localparam logic [3:0] AluSll  = 4'b1010;
    localparam logic [3:0] AluSrl  = 4'b1011;
    localparam logic [3:0] AluLui  = 4'b1100;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExec, StWb, StAddr, StMem, StLwb, StBranch, StTrap
    } state_e;

    typedef enum logic [1:0] {ClsAlu, ClsMem, ClsBranch, ClsBad} cls_e;

    state_e      r_state;
    state_e      w_state_d;

    logic        r_mem_req, r_mem_we, r_pc_src, r_reg_we, r_reg_dst, r_wb_sel, r_illegal;
    logic [1:0]  r_mem_size, r_alu_src_b;
    logic [3:0]  r_alu_ctrl;

    logic        w_mem_req_d, w_mem_we_d, w_pc_src_d, w_reg_we_d, w_reg_dst_d, w_wb_sel_d;
    logic [1:0]  w_mem_size_d, w_alu_src_b_d;
    logic [3:0]  w_alu_ctrl_d;

    logic [5:0]  w_op, w_funct;
    cls_e        w_cls;
    logic [3:0]  w_alu;
    logic [1:0]  w_src_b, w_size;
    logic        w_reg_dst, w_is_store, w_is_beq;
    logic        w_fetch_ack, w_br_take;
    logic        w_unused_instr;

    assign w_op           = i_instr[31:26];
    assign w_funct        = i_instr[5:0];
    assign w_is_beq       = (w_op == 6'h04);
    assign w_unused_instr = ^i_instr[25:6];

    // Instruction decode; only consulted while IR holds the current instruction.
    always_comb begin
        w_cls      = ClsBad;
        w_alu      = AluIdle;
        w_src_b    = 2'd0;
        w_size     = 2'd2;
        w_reg_dst  = 1'b0;
        w_is_store = 1'b0;
        case (w_op)
            6'h00: begin
                w_cls     = ClsAlu;
                w_reg_dst = 1'b1;
                case (w_funct)
                    6'h21:   w_alu = AluAdd;
                    6'h23:   w_alu = AluSub;
                    6'h24:   w_alu = AluAnd;
                    6'h25:   w_alu = AluOr;
                    6'h26:   w_alu = AluXor;
                    6'h2A:   w_alu = AluSlt;
                    6'h2B:   w_alu = AluSltu;
                    6'h00:   w_alu = AluSll;
                    6'h02:   w_alu = AluSrl;
                    default: w_cls = ClsBad;
                endcase
            end
            6'h09:   begin w_cls = ClsAlu; w_alu = AluAdd;  w_src_b = 2'd1; end
            6'h0B:   begin w_cls = ClsAlu; w_alu = AluSltu; w_src_b = 2'd1; end
            6'h0C:   begin w_cls = ClsAlu; w_alu = AluAnd;  w_src_b = 2'd2; end
            6'h0D:   begin w_cls = ClsAlu; w_alu = AluOr;   w_src_b = 2'd2; end
            6'h0F:   begin w_cls = ClsAlu; w_alu = AluLui;  w_src_b = 2'd2; end
            6'h23:   begin w_cls = ClsMem; w_size = 2'd2; end
            6'h24:   begin w_cls = ClsMem; w_size = 2'd0; end
            6'h25:   begin w_cls = ClsMem; w_size = 2'd1; end
            6'h28:   begin w_cls = ClsMem; w_size = 2'd0; w_is_store = 1'b1; end
            6'h29:   begin w_cls = ClsMem; w_size = 2'd1; w_is_store = 1'b1; end
            6'h2B:   begin w_cls = ClsMem; w_size = 2'd2; w_is_store = 1'b1; end
            6'h04,
            6'h05:   w_cls = ClsBranch;
            default: w_cls = ClsBad;
        endcase
    end

    // mem_ready only counts while a request is actually outstanding.
    assign w_fetch_ack = (r_state == StFetch) && r_mem_req && i_mem_ready;
    assign w_br_take   = (r_state == StBranch) && (w_is_beq ? i_alu_zero : !i_alu_zero);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StFetch:  if (w_fetch_ack) w_state_d = StDecode;
            StDecode: begin
                unique case (w_cls)
                    ClsAlu:    w_state_d = StExec;
                    ClsMem:    w_state_d = StAddr;
                    ClsBranch: w_state_d = StBranch;
                    default:   w_state_d = StTrap;
                endcase
            end
            StExec:   w_state_d = StWb;
            StWb:     w_state_d = StFetch;
            StAddr:   w_state_d = StMem;
            StMem: begin
                if (r_mem_req && i_mem_ready) w_state_d = w_is_store ? StFetch : StLwb;
            end
            StLwb:    w_state_d = StFetch;
            StBranch: w_state_d = StFetch;
            StTrap:   w_state_d = StTrap;
            default:  w_state_d = StFetch;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        w_mem_req_d   = 1'b0;
        w_mem_we_d    = 1'b0;
        w_mem_size_d  = 2'd0;
        w_pc_src_d    = 1'b0;
        w_alu_ctrl_d  = AluIdle;
        w_alu_src_b_d = 2'd0;
        w_reg_we_d    = 1'b0;
        w_reg_dst_d   = 1'b0;
        w_wb_sel_d    = 1'b0;
        unique case (w_state_d)
            StFetch: begin
                w_mem_req_d  = 1'b1;
                w_mem_size_d = 2'd2;
            end
            StExec, StWb: begin
                w_alu_ctrl_d  = w_alu;
                w_alu_src_b_d = w_src_b;
                w_reg_dst_d   = w_reg_dst;
                w_reg_we_d    = (w_state_d == StWb);
            end
            StAddr, StMem: begin
                w_alu_ctrl_d  = AluAdd;
                w_alu_src_b_d = 2'd1;
                if (w_state_d == StMem) begin
                    w_mem_req_d  = 1'b1;
                    w_mem_we_d   = w_is_store;
                    w_mem_size_d = w_size;
                end
            end
            StLwb: begin
                w_reg_we_d = 1'b1;
                w_wb_sel_d = 1'b1;
            end
            StBranch: begin
                w_alu_ctrl_d = AluSub;
                w_pc_src_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StFetch;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_size  <= 2'd0;
            r_pc_src    <= 1'b0;
            r_alu_ctrl  <= AluIdle;
            r_alu_src_b <= 2'd0;
            r_reg_we    <= 1'b0;
            r_reg_dst   <= 1'b0;
            r_wb_sel    <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_mem_req   <= w_mem_req_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_size  <= w_mem_size_d;
            r_pc_src    <= w_pc_src_d;
            r_alu_ctrl  <= w_alu_ctrl_d;
            r_alu_src_b <= w_alu_src_b_d;
            r_reg_we    <= w_reg_we_d;
            r_reg_dst   <= w_reg_dst_d;
            r_wb_sel    <= w_wb_sel_d;
            r_illegal   <= r_illegal | (w_state_d == StTrap);
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_size  = r_mem_size;
    assign o_ir_we     = w_fetch_ack;
    assign o_pc_we     = w_fetch_ack | w_br_take;
    assign o_pc_src    = r_pc_src;
    assign o_alu_ctrl  = r_alu_ctrl;
    assign o_alu_src_b = r_alu_src_b;
    assign o_reg_we    = r_reg_we;
    assign o_reg_dst   = r_reg_dst;
    assign o_wb_sel    = r_wb_sel;
    assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: per-cycle expected output vectors are queued
// by the stimulus process and checked by an independent monitor at the falling edge.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_zero, mem_ready;
    logic        mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst, wb_sel, illegal;
    logic [1:0]  mem_size, alu_src_b;
    logic [3:0]  alu_ctrl;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_instr    (instr),
        .i_alu_zero (alu_zero),
        .i_mem_ready(mem_ready),
        .o_mem_req  (mem_req),
        .o_mem_we   (mem_we),
        .o_mem_size (mem_size),
        .o_ir_we    (ir_we),
        .o_pc_we    (pc_we),
        .o_pc_src   (pc_src),
        .o_alu_ctrl (alu_ctrl),
        .o_alu_src_b(alu_src_b),
        .o_reg_we   (reg_we),
        .o_reg_dst  (reg_dst),
        .o_wb_sel   (wb_sel),
        .o_illegal  (illegal)
    );

    // {mem_req, mem_we, mem_size, ir_we, pc_we, pc_src, alu_ctrl, alu_src_b,
    //  reg_we, reg_dst, wb_sel, illegal}
    logic [16:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [16:0] mk(input logic req, we, input logic [1:0] sz,
                                       input logic irwe, pcwe, pcsrc, input logic [3:0] alu,
                                       input logic [1:0] srcb, input logic rwe, rdst, wsel,
                                       ill);
        return {req, we, sz, irwe, pcwe, pcsrc, alu, srcb, rwe, rdst, wsel, ill};
    endfunction

    // Monitor: one popped expectation per cycle while anything is queued.
    always @(negedge clk) begin
        logic [16:0] act, e;
        string       nm;
        if (exp_q.size() > 0) begin
            act = {mem_req, mem_we, mem_size, ir_we, pc_we, pc_src, alu_ctrl, alu_src_b,
                   reg_we, reg_dst, wb_sel, illegal};
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s @%0t: got %b required %b", nm, $time, act, e);
            end
        end
    end

    task automatic step(input logic r, input logic rdy, input logic z, input logic [31:0] ins,
                        input logic [16:0] e, input string nm);
        @(posedge clk);
        #1;
        rst_n     = r;
        mem_ready = rdy;
        alu_zero  = z;
        instr     = ins;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Reference classification from the instruction-set tables.
    // cls: 0 ALU, 1 load/store, 2 branch, 3 unsupported.
    function automatic void ref_decode(input logic [31:0] ins, output int cls,
                                       output logic [3:0] alu, output logic [1:0] srcb,
                                       output logic [1:0] sz, output logic st);
        logic [5:0] r_fn[9]  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02};
        logic [3:0] r_alu[9] = '{4'd5, 4'd6, 4'd1, 4'd3, 4'd2, 4'd9, 4'd8, 4'd10, 4'd11};
        logic [5:0] i_op[5]  = '{6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0F};
        logic [3:0] i_alu[5] = '{4'd5, 4'd8, 4'd1, 4'd3, 4'd12};
        logic [1:0] i_sb[5]  = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
        logic [5:0] m_op[6]  = '{6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        logic [1:0] m_sz[6]  = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
        cls = 3; alu = 4'd0; srcb = 2'd0; sz = 2'd0; st = 1'b0;
        if (ins[31:26] == 6'h00) begin
            for (int i = 0; i < 9; i++) if (ins[5:0] == r_fn[i]) begin cls = 0; alu = r_alu[i]; end
        end
        for (int i = 0; i < 5; i++)
            if (ins[31:26] == i_op[i]) begin cls = 0; alu = i_alu[i]; srcb = i_sb[i]; end
        for (int i = 0; i < 6; i++)
            if (ins[31:26] == m_op[i]) begin cls = 1; sz = m_sz[i]; st = (i >= 3); end
        if (ins[31:26] == 6'h04 || ins[31:26] == 6'h05) cls = 2;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rb(), rb(), $urandom, '0, "reset");
        // Release cycle: state is FETCH but no request is out yet.
        step(1'b1, rb(), rb(), $urandom, '0, "reset_release");
    endtask

    // Runs one instruction; abort_mem pulls reset during the first MEM cycle.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic z, input logic abort_mem);
        int         cls;
        logic [3:0] alu;
        logic [1:0] srcb, sz;
        logic       st, rdst, taken;
        ref_decode(ins, cls, alu, srcb, sz, st);
        rdst = (ins[31:26] == 6'h00);
        for (int i = 0; i < fw; i++)
            step(1'b1, 1'b0, rb(), $urandom, mk(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_wait");
        step(1'b1, 1'b1, rb(), ins, mk(1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0), "fetch_ack");
        step(1'b1, rb(), rb(), ins, '0, "decode");
        case (cls)
            0: begin
                step(1'b1, rb(), rb(), ins, mk(0, 0, 0, 0, 0, 0, alu, srcb, 0, rdst, 0, 0), "exec");
                step(1'b1, rb(), rb(), ins, mk(0, 0, 0, 0, 0, 0, alu, srcb, 1, rdst, 0, 0), "wb");
            end
            1: begin
                step(1'b1, rb(), rb(), ins, mk(0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0), "addr");
                if (abort_mem) begin
                    step(1'b1, 1'b0, rb(), ins, mk(1, st, sz, 0, 0, 0, 5, 1, 0, 0, 0, 0), "mem_wait");
                    do_reset(1);
                    return;
                end
                for (int i = 0; i < mw; i++)
                    step(1'b1, 1'b0, rb(), ins, mk(1, st, sz, 0, 0, 0, 5, 1, 0, 0, 0, 0), "mem_wait");
                step(1'b1, 1'b1, rb(), ins, mk(1, st, sz, 0, 0, 0, 5, 1, 0, 0, 0, 0), "mem_done");
                if (!st) step(1'b1, rb(), rb(), ins, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), "lwb");
            end
            2: begin
                taken = (ins[31:26] == 6'h04) ? z : !z;
                step(1'b1, rb(), z, ins, mk(0, 0, 0, 0, taken, 1, 6, 0, 0, 0, 0, 0), "branch");
            end
            default: begin
                for (int i = 0; i < 4; i++)
                    step(1'b1, rb(), rb(), ins, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "trap");
                do_reset(1);
            end
        endcase
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  r_fn[9] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02};
        logic [5:0]  ops[13] = '{6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h24, 6'h25,
                                 6'h28, 6'h29, 6'h2B, 6'h04, 6'h05};
        logic [5:0]  bad_op[4] = '{6'h3F, 6'h02, 6'h08, 6'h20};
        logic [5:0]  bad_fn[3] = '{6'h08, 6'h20, 6'h03};
        logic [31:0] t = $urandom;
        int          k = $urandom_range(0, 19);
        if (k < 8)  return {6'h00, t[25:6], r_fn[$urandom_range(0, 8)]};
        if (k < 18) return {ops[$urandom_range(0, 12)], t[25:0]};
        if (k == 18) return {6'h00, t[25:6], bad_fn[$urandom_range(0, 2)]};
        return {bad_op[$urandom_range(0, 3)], t[25:0]};
    endfunction

    initial begin
        rst_n = 1'b0; instr = '0; alu_zero = 1'b0; mem_ready = 1'b0;
        do_reset(2);
        // Directed cases.
        run_instr(32'h0000_0021, 0, 0, 1'b0, 1'b0);   // addu
        run_instr(32'h8C00_0000, 0, 3, 1'b0, 1'b0);   // lw, 3 wait cycles
        run_instr(32'hA000_0000, 1, 0, 1'b0, 1'b0);   // sb
        run_instr(32'h1000_0000, 0, 0, 1'b1, 1'b0);   // beq taken
        run_instr(32'h1400_0000, 0, 0, 1'b1, 1'b0);   // bne not taken
        run_instr(32'hFC00_0000, 0, 0, 1'b0, 1'b0);   // illegal op 0x3F, then reset
        run_instr(32'hAC00_0000, 0, 2, 1'b0, 1'b1);   // sw aborted by reset mid-MEM
        run_instr(32'h3C00_1234, 2, 0, 1'b0, 1'b0);   // lui after restart
        // Randomized traffic.
        for (int n = 0; n < 200; n++)
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), rb(), 1'b0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
